// File: rtl/ixc_mc_pkg.sv
// ixc_mc_pkg: shared definitions for the memory-channel credit path.
package ixc_mc_pkg;

    // Credit-message field layout: [31:24] sequence, [23:18] zero, [17:0] count
    localparam int unsigned SEQ_LSB = 24;
    localparam int unsigned CNT_W   = 18;

    // Word-length type, shared with the inbound FIFO acknowledge length
    typedef logic [CNT_W-1:0] len_t;

    // Credit-message sequencer states
    typedef enum logic [1:0] {
        MSG_IDLE = 2'd0,
        MSG_ARM  = 2'd1,
        MSG_SEND = 2'd2
    } msg_state_e;

    // Assemble a credit-return message word
    function automatic logic [31:0] pack_msg(input logic [7:0] seq, input len_t cnt);
        logic [31:0] w;
        w                = '0;
        w[SEQ_LSB +: 8]  = seq;
        w[CNT_W-1:0]     = cnt;
        return w;
    endfunction

endpackage

// File: rtl/ixc_mc_toggle_det.sv
// ixc_mc_toggle_det: turns the FIFO acknowledge toggle into a one-cycle
// acknowledge strobe. The sampling register follows the toggle even
// during reset, so releasing reset never produces a false acknowledge.
module ixc_mc_toggle_det (
    input  logic clk_i,
    input  logic tgl_i,
    output logic ack_o
);

    logic tgl_q;

    // Unconditional sampling of the toggle (reset-transparent)
    always_ff @(posedge clk_i) begin
        tgl_q <= tgl_i;
    end

    assign ack_o = tgl_i ^ tgl_q;

endmodule

// File: rtl/ixc_mc_ack_credit.sv
// ixc_mc_ack_credit: credit gate for the memory-channel inbound FIFO and
// batched, sequenced credit-return messages toward the host transport.
module ixc_mc_ack_credit
    import ixc_mc_pkg::*;
#(
    parameter int unsigned CAPACITY = 65536,
    parameter int unsigned THRESH   = 1024,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ackClk,
    input  logic [17:0] ackLen,
    input  logic        sndValid,
    input  logic [15:0] sndLen,
    output logic        sndReady,
    output logic        credMsgValid,
    input  logic        credMsgReady,
    output logic [31:0] credMsgData,
    output logic [17:0] credAvail,
    output logic        ovfErr
);

    localparam len_t       CAP_L = len_t'(CAPACITY);
    localparam len_t       THR_L = len_t'(THRESH);
    localparam logic [7:0] TO_L  = 8'(TIMEOUT);

    logic        ack;
    len_t        ack_len;
    logic        hs;
    logic [19:0] out_sum;
    logic [19:0] pend_sum;

    len_t        out_q,   out_d;
    len_t        avail_q, avail_d;
    len_t        pend_q,  pend_d;
    len_t        snap_q,  snap_d;
    logic [7:0]  seq_q,   seq_d;
    logic [7:0]  timer_q, timer_d;
    logic        ovf_q,   ovf_d;
    msg_state_e  state_q, state_d;

    ixc_mc_toggle_det u_tdet (
        .clk_i (clk),
        .tgl_i (ackClk),
        .ack_o (ack)
    );

    assign ack_len = ack ? ackLen : '0;

    // Grant is judged against the registered headroom, which already
    // includes last cycle's send, so a packet can never be double-spent
    assign sndReady = sndValid && !rst && ({2'b00, sndLen} <= avail_q);
    assign hs       = (state_q == MSG_SEND) && credMsgReady;

    // Outstanding/pending word counters with underflow clamp and saturation
    always_comb begin
        ovf_d   = ovf_q;
        out_sum = {2'b00, out_q} + (sndReady ? {4'b0000, sndLen} : 20'd0)
                - {2'b00, ack_len};
        if (out_sum[19]) begin
            out_d = '0;
            ovf_d = 1'b1;
        end else if (out_sum[18]) begin
            out_d = '1;
        end else begin
            out_d = out_sum[17:0];
        end
        avail_d = CAP_L - out_d;

        pend_sum = {2'b00, pend_q} + {2'b00, ack_len}
                 - (hs ? {2'b00, snap_q} : 20'd0);
        if (pend_sum[19:18] != 2'b00) begin
            pend_d = '1;
            ovf_d  = 1'b1;
        end else begin
            pend_d = pend_sum[17:0];
        end
    end

    // Message sequencer: batch pending credit, launch on threshold or timeout
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        seq_d   = seq_q;
        timer_d = (state_q == MSG_ARM) ? timer_q + 8'd1 : '0;
        case (state_q)
            MSG_IDLE: begin
                if (pend_q >= THR_L) begin
                    state_d = MSG_SEND;
                end else if (pend_q != '0) begin
                    state_d = MSG_ARM;
                end
            end
            MSG_ARM: begin
                if ((pend_q >= THR_L) || (timer_q == TO_L)) begin
                    state_d = MSG_SEND;
                end
            end
            MSG_SEND: begin
                if (hs) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = (pend_d == '0) ? MSG_IDLE : MSG_ARM;
                end
            end
            default: state_d = MSG_IDLE;
        endcase
        // Snapshot the count as it stands on the launch edge; later
        // acknowledges accumulate in pending for the next message
        if ((state_d == MSG_SEND) && (state_q != MSG_SEND)) begin
            snap_d = pend_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            avail_q <= CAP_L;
            pend_q  <= '0;
            snap_q  <= '0;
            seq_q   <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= MSG_IDLE;
        end else begin
            out_q   <= out_d;
            avail_q <= avail_d;
            pend_q  <= pend_d;
            snap_q  <= snap_d;
            seq_q   <= seq_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign credMsgValid = (state_q == MSG_SEND);
    assign credMsgData  = credMsgValid ? pack_msg(seq_q, snap_q) : '0;
    assign credAvail    = avail_q;
    assign ovfErr       = ovf_q;

endmodule

// File: tb/tb_ixc_mc_ack_credit.sv
// tb_ixc_mc_ack_credit: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the credit stage.
module tb_ixc_mc_ack_credit;

    localparam int unsigned CAP = 65536;
    localparam int unsigned TH  = 1024;
    localparam int unsigned TO  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        ackClk;
    logic [17:0] ackLen;
    logic        sndValid;
    logic [15:0] sndLen;
    logic        sndReady;
    logic        credMsgValid;
    logic        credMsgReady;
    logic [31:0] credMsgData;
    logic [17:0] credAvail;
    logic        ovfErr;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int   m_out;
    int   m_pend;
    int   m_seq;
    int   m_snap;
    int   m_age;     // cycles spent waiting with credit armed, -1 when not armed
    bit   m_busy;    // a message is being offered
    bit   m_ovf;
    logic m_ackq;

    always #5 clk = ~clk;

    ixc_mc_ack_credit #(
        .CAPACITY (CAP),
        .THRESH   (TH),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ackClk       (ackClk),
        .ackLen       (ackLen),
        .sndValid     (sndValid),
        .sndLen       (sndLen),
        .sndReady     (sndReady),
        .credMsgValid (credMsgValid),
        .credMsgReady (credMsgReady),
        .credMsgData  (credMsgData),
        .credAvail    (credAvail),
        .ovfErr       (ovfErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_out  = 0;
        m_pend = 0;
        m_seq  = 0;
        m_snap = 0;
        m_age  = -1;
        m_busy = 0;
        m_ovf  = 0;
    endtask

    // Advance the model across one clock edge using the current inputs
    task automatic model_edge();
        bit ack, acc, hs;
        int a, nout, npend;
        ack    = (ackClk != m_ackq);
        m_ackq = ackClk;
        if (rst) begin
            model_reset();
            return;
        end
        a    = ack ? int'(ackLen) : 0;
        acc  = sndValid && (int'(sndLen) <= int'(CAP) - m_out);
        nout = m_out + (acc ? int'(sndLen) : 0) - a;
        if (nout < 0) begin
            nout  = 0;
            m_ovf = 1;
        end
        hs    = m_busy && credMsgReady;
        npend = m_pend + a - (hs ? m_snap : 0);
        if (npend > 262143) begin
            npend = 262143;
            m_ovf = 1;
        end
        if (m_busy) begin
            if (hs) begin
                m_busy = 0;
                m_seq  = (m_seq + 1) % 256;
                m_age  = (npend == 0) ? -1 : 0;
            end
        end else if (m_age < 0) begin
            if (m_pend >= int'(TH)) begin
                m_busy = 1;
                m_snap = m_pend;
            end else if (m_pend > 0) begin
                m_age = 0;
            end
        end else begin
            if (m_pend >= int'(TH) || m_age == int'(TO)) begin
                m_busy = 1;
                m_snap = m_pend;
                m_age  = -1;
            end else begin
                m_age++;
            end
        end
        m_out  = nout;
        m_pend = npend;
    endtask

    // Compare every output to the model, then take one clock edge
    task automatic step();
        logic        exp_rdy;
        logic [31:0] exp_data;
        #1;
        exp_rdy  = sndValid && !rst && (int'(sndLen) <= int'(CAP) - m_out);
        exp_data = m_busy ? ((32'(m_seq) << 24) | 32'(m_snap)) : 32'd0;
        check("sndReady",     32'(sndReady),     32'(exp_rdy));
        check("credMsgValid", 32'(credMsgValid), 32'(m_busy));
        check("credMsgData",  credMsgData,       exp_data);
        check("credAvail",    32'(credAvail),    32'(int'(CAP) - m_out));
        check("ovfErr",       32'(ovfErr),       32'(m_ovf));
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input int len);
        sndValid = 1'b1;
        sndLen   = 16'(len);
        step();
        sndValid = 1'b0;
    endtask

    task automatic ack_words(input int len);
        ackClk = ~ackClk;
        ackLen = 18'(len);
        step();
    endtask

    // Step until a message is offered, bounded by limit cycles
    task automatic wait_valid(input int limit, output int waited);
        waited = 0;
        while (!credMsgValid && waited < limit) begin
            step();
            waited++;
        end
        check("msg_seen", 32'(credMsgValid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        rst          = 1'b1;
        ackClk       = 1'b1;
        ackLen       = '0;
        sndValid     = 1'b0;
        sndLen       = '0;
        credMsgReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        m_ackq = ackClk;

        // Reset with ackClk held high: no false acknowledge on release
        pulse_reset();
        repeat (3) step();
        check("rst_avail", 32'(credAvail),    32'd65536);
        check("rst_valid", 32'(credMsgValid), 32'd0);
        check("rst_ovf",   32'(ovfErr),       32'd0);

        // Threshold message
        send(1024);
        check("thr_avail_send", 32'(credAvail), 32'd64512);
        ack_words(1024);
        check("thr_avail_ack", 32'(credAvail),    32'd65536);
        check("thr_valid_n1",  32'(credMsgValid), 32'd0);
        step();
        check("thr_valid_n2", 32'(credMsgValid), 32'd1);
        check("thr_data",     credMsgData,       32'h0000_0400);
        step();
        check("thr_done", 32'(credMsgValid), 32'd0);

        // Timeout message and sequence advance
        pulse_reset();
        send(4000);
        ack_words(5);
        step();
        wait_valid(400, w);
        check("to_latency", 32'(w),      32'(TO + 1));
        check("to_data",    credMsgData, 32'h0000_0005);
        step();
        ack_words(7);
        wait_valid(400, w);
        check("to_seq1", credMsgData, 32'h0100_0007);
        step();

        // Backpressure: held message stays fixed while acks accumulate
        pulse_reset();
        send(4000);
        credMsgReady = 1'b0;
        ack_words(2000);
        step();
        check("bp_valid", 32'(credMsgValid), 32'd1);
        check("bp_data",  credMsgData,       32'h0000_07D0);
        for (int i = 0; i < 20; i++) begin
            if (i == 3 || i == 8 || i == 13) ack_words(1);
            else step();
            check("bp_hold", credMsgData, 32'h0000_07D0);
        end
        credMsgReady = 1'b1;
        step();
        check("bp_released", 32'(credMsgValid), 32'd0);
        wait_valid(400, w);
        check("bp_arm_latency", 32'(w),      32'(TO + 1));
        check("bp_rest",        credMsgData, 32'h0100_0003);
        step();

        // Credit starvation
        pulse_reset();
        send(65526);
        check("st_avail", 32'(credAvail), 32'd10);
        sndValid = 1'b1;
        sndLen   = 16'd11;
        #1;
        check("st_block", 32'(sndReady), 32'd0);
        ack_words(1);
        check("st_grant", 32'(sndReady), 32'd1);
        step();
        sndValid = 1'b0;
        check("st_spent", 32'(credAvail), 32'd0);

        // Underflow error: clamp and sticky flag
        pulse_reset();
        send(2);
        ack_words(5);
        check("err_clamp", 32'(credAvail), 32'd65536);
        check("err_set",   32'(ovfErr),    32'd1);
        repeat (5) step();
        check("err_sticky", 32'(ovfErr), 32'd1);
        pulse_reset();
        check("err_clear", 32'(ovfErr), 32'd0);

        // Sequence wrap across 257 messages, send and ack in the same cycle
        for (int i = 0; i < 257; i++) begin
            sndValid = 1'b1;
            sndLen   = 16'd1024;
            ack_words(1024);
            sndValid = 1'b0;
            wait_valid(10, w);
            check("wrap_seq", 32'(credMsgData[31:24]), 32'(i % 256));
            step();
        end

        // Randomized traffic including occasional resets
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 599) == 0);
            sndValid = 1'($urandom_range(0, 1));
            sndLen   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 65535))
                                                   : 16'($urandom_range(0, 300));
            if ($urandom_range(0, 2) == 0) begin
                ackClk = ~ackClk;
                ackLen = ($urandom_range(0, 19) == 0)
                         ? 18'($urandom_range(0, 2000))
                         : 18'($urandom_range(0, (m_out < 400) ? m_out : 400));
            end
            credMsgReady = ($urandom_range(0, 9) < 7);
            step();
        end
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
